// File: rtl/log_pkg.sv
// Shared constants and types for the log drain: item geometry and the beat FSM states.
package log_pkg;
  localparam int DATA_SIZE_DEF  = 32;
  localparam int TAG_SIZE_DEF   = 8;
  localparam int BEATS_PER_ITEM = 3;

  // Condensed item: 4 flag bits, two data words and the network tag.
  function automatic int item_width(input int ds, input int ts);
    return 4 + 2 * ds + ts;
  endfunction

  localparam int ITEM_WIDTH = item_width(DATA_SIZE_DEF, TAG_SIZE_DEF);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, BEAT2} beat_state_t;
endpackage

// File: rtl/log_fifo.sv
// Synchronous item FIFO; pointers carry one extra wrap bit so full and empty differ.
module log_fifo #(
  parameter  int WIDTH = 76,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_level   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr_en   = i_push && !o_full;
  assign w_rd_en   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is left uninitialised; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end
endmodule

// File: rtl/log_drain.sv
// Buffers condensed log items and serialises each into three DATA_SIZE beats
// on a valid/ready stream, counting items lost to overflow.
module log_drain
  import log_pkg::*;
#(
  parameter  int DATA_SIZE  = 32,
  parameter  int TAG_SIZE   = 8,
  parameter  int FIFO_DEPTH = 16,
  localparam int ITEM_W     = item_width(DATA_SIZE, TAG_SIZE),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ITEM_W-1:0]    log_item_in,
  input  logic                 log_valid_in,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [LVL_W-1:0]     fill_level,
  output logic [15:0]          drop_count,
  output logic                 overflow
);
  beat_state_t         r_state;
  logic [ITEM_W-1:0]   r_hold;
  logic [ITEM_W-1:0]   w_fifo_data;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [DATA_SIZE-1:0] w_top_beat;

  assign w_push     = log_valid_in && !reset && !w_full;
  // Pop from IDLE, or chain straight into the next item when BEAT2 is taken.
  assign w_pop      = !w_empty && ((r_state == IDLE) || (r_state == BEAT2 && out_ready));
  assign w_top_beat = DATA_SIZE'(r_hold[ITEM_W-1:2*DATA_SIZE]);

  log_fifo #(.WIDTH(ITEM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_wr_data (log_item_in),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fill_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (log_valid_in && w_full) begin
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          r_hold    <= w_fifo_data;
          out_data  <= w_fifo_data[DATA_SIZE-1:0];
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          r_state   <= BEAT0;
        end
        BEAT0: if (out_ready) begin
          out_data <= r_hold[2*DATA_SIZE-1:DATA_SIZE];
          r_state  <= BEAT1;
        end
        BEAT1: if (out_ready) begin
          out_data <= w_top_beat;
          out_last <= 1'b1;
          r_state  <= BEAT2;
        end
        BEAT2: if (out_ready) begin
          if (w_pop) begin
            r_hold    <= w_fifo_data;
            out_data  <= w_fifo_data[DATA_SIZE-1:0];
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            r_state   <= BEAT0;
          end else begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_log_drain.sv
// Directed bench for log_drain: a vector table for single-item and backpressure
// traffic, then hand-written overflow, full-plus-pop, back-to-back and reset runs.
module tb_log_drain;
  logic        clk = 1'b0;
  logic        reset;
  logic [75:0] log_item_in;
  logic        log_valid_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [4:0]  fill_level;
  logic [15:0] drop_count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  log_drain dut (
    .clk          (clk),
    .reset        (reset),
    .log_item_in  (log_item_in),
    .log_valid_in (log_valid_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .fill_level   (fill_level),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  typedef struct {
    logic        rst;
    logic        vin;
    logic [75:0] item;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [4:0]  ef;
    logic [15:0] edc;
    logic        eo;
  } vec_t;

  vec_t tv[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic vin, input logic [75:0] item,
                              input logic rdy, input logic ev, input logic [31:0] ed,
                              input logic el, input logic [4:0] ef, input logic [15:0] edc,
                              input logic eo);
    vec_t v;
    v.rst = rst; v.vin = vin; v.item = item; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.ef = ef; v.edc = edc; v.eo = eo;
    return v;
  endfunction

  function automatic logic [31:0] beat(input logic [75:0] it, input int b);
    case (b)
      0:       return it[31:0];
      1:       return it[63:32];
      default: return {20'h0, it[75:64]};
    endcase
  endfunction

  function automatic logic [75:0] mk_item(input int i);
    logic [11:0] t;
    t = 12'(i) + 12'h100;
    return {t, 32'hC0DE0000 + 32'(i), 32'h5A5A0000 + 32'(i)};
  endfunction

  initial begin
    logic [75:0] a;
    logic [75:0] filler;
    logic [75:0] exp_it;
    a      = 76'hABC_1234_5678_9ABC_DEF0;
    filler = 76'h111_2222_2222_3333_3333;

    // rst vin item rdy | valid data last fill drops ovf
    tv[0]  = mk(1, 1, a, 1, 0, 32'h0,        0, 0, 0, 0);
    tv[1]  = mk(0, 1, a, 1, 0, 32'h0,        0, 1, 0, 0);
    tv[2]  = mk(0, 0, 0, 1, 1, 32'h9ABCDEF0, 0, 0, 0, 0);
    tv[3]  = mk(0, 0, 0, 1, 1, 32'h12345678, 0, 0, 0, 0);
    tv[4]  = mk(0, 0, 0, 1, 1, 32'h00000ABC, 1, 0, 0, 0);
    tv[5]  = mk(0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0);
    tv[6]  = mk(0, 1, a, 1, 0, 32'h0,        0, 1, 0, 0);
    tv[7]  = mk(0, 0, 0, 0, 1, 32'h9ABCDEF0, 0, 0, 0, 0);
    tv[8]  = mk(0, 0, 0, 1, 1, 32'h12345678, 0, 0, 0, 0);
    for (int i = 9; i < 14; i++)
      tv[i] = mk(0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0);
    tv[14] = mk(0, 0, 0, 1, 1, 32'h00000ABC, 1, 0, 0, 0);
    tv[15] = mk(0, 0, 0, 1, 0, 32'h0,        0, 0, 0, 0);

    reset = 1'b1; log_valid_in = 1'b0; log_item_in = '0; out_ready = 1'b0;

    for (int i = 0; i < 16; i++) begin
      reset = tv[i].rst; log_valid_in = tv[i].vin;
      log_item_in = tv[i].item; out_ready = tv[i].rdy;
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("v%0d out_data", i), out_data, tv[i].ed);
      chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(tv[i].el));
      chk($sformatf("v%0d fill_level", i), 32'(fill_level), 32'(tv[i].ef));
      chk($sformatf("v%0d drop_count", i), 32'(drop_count), 32'(tv[i].edc));
      chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(tv[i].eo));
    end
    log_valid_in = 1'b0;

    // Overflow: filler parks in the hold register, then 20 items hit a stalled drain.
    out_ready = 1'b0;
    log_valid_in = 1'b1; log_item_in = filler;
    tick();
    log_valid_in = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      log_valid_in = 1'b1; log_item_in = mk_item(i);
      tick();
    end
    log_valid_in = 1'b0;
    chk("ovf fill_level", 32'(fill_level), 32'd16);
    chk("ovf drop_count", 32'(drop_count), 32'd4);
    chk("ovf overflow", 32'(overflow), 32'd1);
    chk("ovf out_valid", 32'(out_valid), 32'd1);
    chk("ovf out_data", out_data, beat(filler, 0));

    // Drain; a push lands on the cycle the filler's BEAT2 is taken while full.
    out_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      exp_it = (j == 0) ? filler : mk_item(j - 1);
      for (int b = 0; b < 3; b++) begin
        chk($sformatf("drain%0d.%0d valid", j, b), 32'(out_valid), 32'd1);
        chk($sformatf("drain%0d.%0d data", j, b), out_data, beat(exp_it, b));
        chk($sformatf("drain%0d.%0d last", j, b), 32'(out_last), 32'(b == 2));
        log_valid_in = (j == 0 && b == 2); log_item_in = 76'hDEAD;
        tick();
        log_valid_in = 1'b0;
        if (j == 0 && b == 2) begin
          chk("fullpop fill_level", 32'(fill_level), 32'd15);
          chk("fullpop drop_count", 32'(drop_count), 32'd5);
        end
      end
    end
    chk("drained out_valid", 32'(out_valid), 32'd0);
    chk("drained fill_level", 32'(fill_level), 32'd0);

    // Back-to-back: four items, twelve beats with no idle gap.
    for (int c = 0; c < 13; c++) begin
      log_valid_in = (c < 4); log_item_in = mk_item(100 + c);
      tick();
      log_valid_in = 1'b0;
      if (c >= 1) begin
        chk($sformatf("b2b%0d valid", c - 1), 32'(out_valid), 32'd1);
        chk($sformatf("b2b%0d data", c - 1), out_data, beat(mk_item(100 + (c - 1) / 3), (c - 1) % 3));
        chk($sformatf("b2b%0d last", c - 1), 32'(out_last), 32'((c - 1) % 3 == 2));
      end
    end
    tick();
    chk("b2b idle", 32'(out_valid), 32'd0);

    // Reset mid-item: BEAT1 on screen, three items queued, drop counter non-zero.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      log_valid_in = 1'b1; log_item_in = mk_item(200 + c);
      tick();
    end
    log_valid_in = 1'b0; out_ready = 1'b1;
    tick();
    chk("rst pre data", out_data, beat(mk_item(200), 1));
    chk("rst pre fill", 32'(fill_level), 32'd3);
    reset = 1'b1; log_valid_in = 1'b1; log_item_in = mk_item(300);
    tick();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst fill_level", 32'(fill_level), 32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    reset = 1'b0; log_valid_in = 1'b1; log_item_in = mk_item(400);
    tick();
    log_valid_in = 1'b0;
    chk("post-rst N+1 valid", 32'(out_valid), 32'd0);
    chk("post-rst N+1 fill", 32'(fill_level), 32'd1);
    tick();
    chk("post-rst N+2 valid", 32'(out_valid), 32'd1);
    chk("post-rst N+2 data", out_data, beat(mk_item(400), 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
